// File: rtl/fdivsqrt_iter_ctrl.sv
// fdivsqrt_iter_ctrl: iteration controller (start pulse, busy enable, cycle count, held done) for the div/sqrt datapath
//
// Ports:
//   clk, resetn    clock, asynchronous active-low reset
//   FDivStartE     begin a divide/sqrt operation (accepted only in IDLE without FlushE)
//   SpecialCaseE   special operands: skip iterations, go straight to DONE
//   CyclesE        iteration count, sampled on accept (0 behaves as 1)
//   WZeroE         residual-is-zero flag; only used with FDIVSQRT_EARLY_TERM_EN
//   StallM         holds DONE while the Memory stage cannot take the result
//   FlushE         squash: forces IDLE and clears the counter
//   IFDivStartE    datapath initialization select (accept cycle only)
//   FDivBusyE      datapath register enable / pipeline stall
//   FDivDoneE      result valid
//   IterCnt        iterations remaining
//
// Optional feature macro: FDIVSQRT_EARLY_TERM_EN (early exit on zero residual).
module fdivsqrt_iter_ctrl #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          FDivStartE,
    input  logic          SpecialCaseE,
    input  logic [CW-1:0] CyclesE,
    input  logic          WZeroE,
    input  logic          StallM,
    input  logic          FlushE,
    output logic          IFDivStartE,
    output logic          FDivBusyE,
    output logic          FDivDoneE,
    output logic [CW-1:0] IterCnt
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state;
    logic   go, accept, last;
    assign go     = (state == IDLE) & FDivStartE & ~FlushE;
    assign accept = go & ~SpecialCaseE;
`ifdef FDIVSQRT_EARLY_TERM_EN
    // The residual still holds its initial value on the first BUSY cycle, so WZeroE is ignored there.
    logic first;
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) first <= 1'b0;
        else         first <= accept;
    assign last = (IterCnt <= CW'(1)) | (WZeroE & ~first);
`else
    logic unused_wzero;
    assign unused_wzero = WZeroE;
    assign last = IterCnt <= CW'(1);
`endif
    // Combinational outputs are gated by resetn so they read 0 for the whole time reset is held.
    assign IFDivStartE = resetn & accept;
    assign FDivBusyE   = resetn & (go | (state == BUSY));
    assign FDivDoneE   = resetn & (state == DONE);
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            IterCnt <= '0;
        end else if (FlushE) begin
            state   <= IDLE;
            IterCnt <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    state   <= BUSY;
                    IterCnt <= (CyclesE == '0) ? CW'(1) : CyclesE;
                end else if (go) state <= DONE;
                BUSY: if (last) begin
                    state   <= DONE;
                    IterCnt <= '0;
                end else IterCnt <= IterCnt - CW'(1);
                DONE: if (!StallM) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fdivsqrt_iter_ctrl.sv
// tb_fdivsqrt_iter_ctrl: randomized self-checking bench for fdivsqrt_iter_ctrl against a timeline model
module tb_fdivsqrt_iter_ctrl;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       FDivStartE = 1'b0, SpecialCaseE = 1'b0, WZeroE = 1'b0, StallM = 1'b0, FlushE = 1'b0;
    logic [7:0] CyclesE = '0;
    logic       IFDivStartE, FDivBusyE, FDivDoneE;
    logic [7:0] IterCnt;
    int         tests = 0, fails = 0;

    fdivsqrt_iter_ctrl #(.CW(8)) dut (
        .clk(clk), .resetn(resetn), .FDivStartE(FDivStartE), .SpecialCaseE(SpecialCaseE),
        .CyclesE(CyclesE), .WZeroE(WZeroE), .StallM(StallM), .FlushE(FlushE),
        .IFDivStartE(IFDivStartE), .FDivBusyE(FDivBusyE), .FDivDoneE(FDivDoneE), .IterCnt(IterCnt)
    );

    always #5 clk = ~clk;

    // Builds the expected per-cycle output timeline of one operation from the latency rules,
    // then drives it cycle by cycle (inputs at negedge, outputs checked 1ns later).
    // c: CyclesE, sp: special case, s: StallM cycles after DONE entry,
    // wz: busy cycle carrying WZeroE (0 = none), fl: busy cycle carrying FlushE (0 = none).
    task automatic run_op(input string name, input int c, input bit sp, input int s, input int wz, input int fl);
        int n, nb, f, len;
        bit last;
        bit es[40], eb[40], ed[40];
        logic [7:0] ec[40];
        n  = (c == 0) ? 1 : c;
        nb = sp ? 0 : n;
`ifdef FDIVSQRT_EARLY_TERM_EN
        if (!sp && wz >= 2 && wz < n) nb = wz;
`endif
        f   = (fl >= 1 && fl <= nb) ? fl : 0;
        len = (f != 0) ? f + 2 : nb + s + 3;
        for (int k = 0; k < 40; k++) begin
            es[k] = 0; eb[k] = 0; ed[k] = 0; ec[k] = '0;
        end
        es[0] = !sp;
        eb[0] = 1;
        for (int k = 1; k <= ((f != 0) ? f : nb); k++) begin
            eb[k] = 1;
            ec[k] = 8'(n - (k - 1));
        end
        if (f == 0)
            for (int k = nb + 1; k <= nb + 1 + s; k++) ed[k] = 1;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            last         = (k == len - 1);
            FDivStartE   = (k == 0) ? 1'b1 : (last ? 1'b0 : 1'($urandom));
            SpecialCaseE = (k == 0) ? sp : 1'($urandom);
            CyclesE      = (k == 0) ? 8'(c) : 8'($urandom);
            WZeroE       = (k > 0 && k == wz && !sp);
            FlushE       = (f != 0 && k == f);
            StallM       = (k > nb && k <= nb + s) ? 1'b1 : ((k <= nb) ? 1'($urandom) : 1'b0);
            #1;
            tests++;
            if ({IFDivStartE, FDivBusyE, FDivDoneE, IterCnt} !== {es[k], eb[k], ed[k], ec[k]}) begin
                fails++;
                $display("FAIL %s cyc %0d: start/busy/done/cnt got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                         name, k, IFDivStartE, FDivBusyE, FDivDoneE, IterCnt, es[k], eb[k], ed[k], ec[k]);
            end
        end
        WZeroE = 0; FlushE = 0; StallM = 0; SpecialCaseE = 0;
    endtask

    task automatic test_reset();
        FDivStartE = 1;
        #1;
        tests++;
        if ({IFDivStartE, FDivBusyE, FDivDoneE, IterCnt} !== 11'b0) begin
            fails++;
            $display("FAIL reset: start/busy/done/cnt got %b/%b/%b/%0d expected 0/0/0/0",
                     IFDivStartE, FDivBusyE, FDivDoneE, IterCnt);
        end
        @(negedge clk);
        FDivStartE = 0;
        resetn = 1;
    endtask

    task automatic test_basic();
        run_op("basic", 5, 0, 0, 0, 0);
    endtask

    task automatic test_special();
        run_op("special", 7, 1, 0, 0, 0);
    endtask

    task automatic test_stall();
        run_op("stall", 2, 0, 3, 0, 0);
    endtask

    task automatic test_flush();
        run_op("flush", 10, 0, 0, 0, 3);
        @(negedge clk);
        FDivStartE = 1; FlushE = 1; CyclesE = 8'd5;
        #1;
        tests++;
        if ({IFDivStartE, FDivBusyE} !== 2'b00) begin
            fails++;
            $display("FAIL flush_start: start/busy got %b/%b expected 0/0", IFDivStartE, FDivBusyE);
        end
        @(negedge clk);
        FDivStartE = 0; FlushE = 0;
        #1;
        tests++;
        if ({IFDivStartE, FDivBusyE, FDivDoneE, IterCnt} !== 11'b0) begin
            fails++;
            $display("FAIL flush_idle: start/busy/done/cnt got %b/%b/%b/%0d expected 0/0/0/0",
                     IFDivStartE, FDivBusyE, FDivDoneE, IterCnt);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        FDivStartE = 1; CyclesE = 8'd10;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            FDivStartE = 0;
        end
        #1;
        tests++;
        if (IterCnt !== 8'd4) begin
            fails++;
            $display("FAIL reset_mid_cnt: IterCnt got %0d expected 4", IterCnt);
        end
        #2;
        resetn = 0; FDivStartE = 1;
        #1;
        tests++;
        if ({IFDivStartE, FDivBusyE, FDivDoneE, IterCnt} !== 11'b0) begin
            fails++;
            $display("FAIL reset_mid: start/busy/done/cnt got %b/%b/%b/%0d expected 0/0/0/0",
                     IFDivStartE, FDivBusyE, FDivDoneE, IterCnt);
        end
        @(negedge clk);
        resetn = 1; FDivStartE = 0;
        repeat (2) begin
            @(negedge clk);
            #1;
            tests++;
            if ({FDivBusyE, FDivDoneE, IterCnt} !== 10'b0) begin
                fails++;
                $display("FAIL reset_release: busy/done/cnt got %b/%b/%0d expected 0/0/0",
                         FDivBusyE, FDivDoneE, IterCnt);
            end
        end
    endtask

    task automatic test_zero_cycles();
        run_op("zero_cycles", 0, 0, 1, 0, 0);
    endtask

    task automatic test_early_term();
        run_op("early_term", 8, 0, 0, 3, 0);
        run_op("early_first_ignored", 4, 0, 0, 1, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            int c, n, s, wz, fl;
            bit sp;
            c  = $urandom_range(0, 12);
            n  = (c == 0) ? 1 : c;
            sp = ($urandom_range(0, 3) == 0);
            s  = $urandom_range(0, 3);
            wz = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n) : 0;
            fl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n) : 0;
            run_op("random", c, sp, s, wz, fl);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_special();
        test_stall();
        test_flush();
        test_reset_mid();
        test_zero_cycles();
        test_early_term();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fdivsqrt_iter_ctrl.md
Name: fdivsqrt_iter_ctrl

Overview:
- Iteration controller for the divide/square-root unit; sits directly upstream of the iteration datapath.
- Accepts a start request in Execute and generates the datapath's initialization pulse (IFDivStartE) and register enable (FDivBusyE).
- Counts iteration cycles, supports early exit for special-case operands, and holds a done indication until the Memory stage is free to consume the result.

Parameters:
- CW, 8, width of the iteration-cycle count and counter.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- FDivStartE  in  1  request to begin a divide/sqrt operation
- SpecialCaseE  in  1  NaN/Inf/zero/divide-by-zero operand; no iterations needed
- CyclesE  in  CW  iteration cycles required; sampled on accepted start
- WZeroE  in  1  residual-is-zero flag from datapath (used only with the optional feature)
- StallM  in  1  Memory stage stalled; result cannot be taken
- FlushE  in  1  squash the operation in Execute
- IFDivStartE  out  1  initialization select for datapath muxes
- FDivBusyE  out  1  datapath register enable; also stalls the pipeline
- FDivDoneE  out  1  result valid for postprocessing
- IterCnt  out  CW  iterations remaining (visible for verification)

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (resetn).
- Reset (resetn low, asynchronous):
  - state = IDLE; IterCnt = 0.
  - FDivBusyE = 0, FDivDoneE = 0.
  - IFDivStartE is forced to 0 while resetn is low.
- State machine, IDLE / BUSY / DONE:
  - IDLE, start accepted (FDivStartE & ~FlushE & ~SpecialCaseE): IFDivStartE = 1 and FDivBusyE = 1 combinationally, so datapath registers load X/init. IterCnt <= max(CyclesE, 1). Next state BUSY.
  - IDLE, special case (FDivStartE & ~FlushE & SpecialCaseE): IFDivStartE = 0, FDivBusyE = 1 for this cycle only. Next state DONE; IterCnt unchanged (0).
  - IDLE, otherwise: all outputs 0.
  - BUSY: FDivBusyE = 1, IFDivStartE = 0. Each clock IterCnt <= IterCnt - 1. When IterCnt == 1, next state DONE and IterCnt <= 0.
  - DONE: FDivDoneE = 1, FDivBusyE = 0. Stays in DONE while StallM = 1; goes to IDLE when StallM = 0.
- Latency:
  - Start-accept cycle, then exactly N BUSY cycles (N = max(CyclesE, 1)), then DONE.
  - FDivDoneE first asserts N+1 cycles after the accept edge.
  - Special case: FDivDoneE asserts on the cycle after the request.
- FlushE priority:
  - FlushE = 1 in any state forces next state IDLE and IterCnt <= 0.
  - FDivDoneE is not asserted on the cycle after a flush.
  - A start coincident with FlushE is not accepted (IFDivStartE = 0).
- Start in BUSY or DONE is ignored. There is no queuing; the pipeline is already stalled by FDivBusyE.
- CyclesE = 0 is treated as 1.
- IterCnt never wraps: decrement happens only when IterCnt ≥ 1.
- Reset asserted mid-operation returns to IDLE immediately. FDivDoneE is never asserted for the aborted operation.
- Without the optional feature, WZeroE is ignored.

Optional Feature:
- Macro: FDIVSQRT_EARLY_TERM_EN.
- Defined: in BUSY, WZeroE = 1 on any BUSY cycle after the first forces next state DONE and IterCnt <= 0. FDivDoneE then asserts one cycle later than the early-exit point instead of after the full count. WZeroE on the first BUSY cycle is ignored, because the residual still holds its initial value.
- Not defined: WZeroE has no effect; the full N iterations always run.

Test Plan:
- Basic op: CyclesE = 5, pulse FDivStartE with StallM = 0 → IFDivStartE = 1 for 1 cycle; FDivBusyE = 1 for 6 cycles; IterCnt 5,4,3,2,1; FDivDoneE = 1 for 1 cycle; back to IDLE.
- Special case: FDivStartE = 1, SpecialCaseE = 1 → IFDivStartE stays 0; FDivBusyE = 1 for 1 cycle; FDivDoneE = 1 on the next cycle.
- Stall hold: CyclesE = 2, StallM = 1 held for 3 cycles after DONE is entered → FDivDoneE stays 1 for 4 cycles; drops the cycle after StallM falls.
- Flush: CyclesE = 10, FlushE on the 3rd BUSY cycle → next cycle IDLE with IterCnt = 0 and FDivBusyE = 0; FDivDoneE never asserts. A start with FlushE = 1 in IDLE gives IFDivStartE = 0.
- Reset and boundaries:
  - resetn low mid-BUSY with IterCnt = 4 → all outputs 0 immediately.
  - After release, CyclesE = 0 → exactly 1 BUSY cycle.
  - FDivStartE held high during BUSY → no re-initialization.
- Early term (macro defined): CyclesE = 8, WZeroE = 1 on the 3rd BUSY cycle → DONE next cycle, IterCnt = 0. Without the macro the same stimulus gives 8 BUSY cycles.
